// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data load/store (D).
// Optional D-access alignment checker is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_sign,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              MEM_W,
  output logic              MEM_R,
  output logic              MEM_S,
  output logic [1:0]        MEM_C,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  state_e            state_q;
  logic              owner_d_q;
  logic              last_d_q;
  logic              we_q;
  logic              sign_q;
  logic [1:0]        size_q;
  logic [3:0]        wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              mem_w_q;
  logic              mem_r_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic              d_err_q;

  logic grant_d;
  logic misaligned;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_d = 1'b0;
    if (d_req && i_req) begin
      grant_d = !last_d_q;
    end else if (d_req) begin
      grant_d = 1'b1;
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (grant_d) begin
      case (d_size)
        2'b01:   misaligned = d_addr[0];
        2'b10:   misaligned = 1'b0;
        default: misaligned = |d_addr[1:0];
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_d_q <= 1'b0;
      last_d_q  <= 1'b0;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= 2'b00;
      wcnt_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_w_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            owner_d_q <= grant_d;
            last_d_q  <= grant_d;
            wcnt_q    <= WaitInit;
            d_err_q   <= misaligned;
            if (grant_d) begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              we_q    <= d_we;
              size_q  <= d_size;
              sign_q  <= d_sign;
            end else begin
              addr_q  <= i_addr;
              we_q    <= 1'b0;
              size_q  <= 2'b00;
              sign_q  <= 1'b0;
            end
            if (misaligned) begin
              // Rejected access: respond immediately without touching memory.
              d_rdata_q <= '0;
              d_ack_q   <= 1'b1;
              state_q   <= StResp;
            end else begin
              mem_w_q <= grant_d && d_we;
              mem_r_q <= !(grant_d && d_we);
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            if (!we_q) begin
              if (owner_d_q) begin
                d_rdata_q <= mem_rdata;
              end else begin
                i_rdata_q <= mem_rdata;
              end
            end
            mem_w_q <= 1'b0;
            mem_r_q <= 1'b0;
            i_ack_q <= !owner_d_q;
            d_ack_q <= owner_d_q;
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign MEM_W     = mem_w_q;
  assign MEM_R     = mem_r_q;
  assign MEM_S     = sign_q;
  assign MEM_C     = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: byte-array reference memory, random I/D traffic,
// plus a second instance with three wait states.
module tb_mem_port_arbiter;

  localparam int unsigned WS   = 0;
  localparam int unsigned WS_B = 3;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          pulses;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = 2'b00;
  logic        i_ack, d_ack, d_err, MEM_W, MEM_R, MEM_S, busy;
  logic [1:0]  MEM_C;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.WAIT_STATES(WS), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .MEM_W(MEM_W), .MEM_R(MEM_R), .MEM_S(MEM_S), .MEM_C(MEM_C),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Wait-state instance with a stateless memory returning ~address
  logic        b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0, b_d_sign = 1'b0;
  logic [31:0] b_i_addr = '0, b_d_addr = '0, b_d_wdata = '0;
  logic [1:0]  b_d_size = 2'b00;
  logic        b_i_ack, b_d_ack, b_d_err, b_mem_w, b_mem_r, b_mem_s, b_busy;
  logic [1:0]  b_mem_c;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  assign b_mem_rdata = ~b_mem_addr;

  mem_port_arbiter #(.WAIT_STATES(WS_B), .ADDR_W(32)) u_dut_ws (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_size(b_d_size), .d_sign(b_d_sign),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .d_err(b_d_err), .MEM_W(b_mem_w), .MEM_R(b_mem_r), .MEM_S(b_mem_s), .MEM_C(b_mem_c),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory device seen by the main instance
  logic [7:0] dev_mem [256];
  logic [7:0] golden  [256];
  logic [7:0] mb0, mb1, mb2, mb3;

  assign mb0 = dev_mem[mem_addr[7:0]];
  assign mb1 = dev_mem[mem_addr[7:0] + 8'd1];
  assign mb2 = dev_mem[mem_addr[7:0] + 8'd2];
  assign mb3 = dev_mem[mem_addr[7:0] + 8'd3];

  always_comb begin
    mem_rdata = {mb3, mb2, mb1, mb0};
    if (MEM_C == 2'b10) mem_rdata = {{24{MEM_S & mb0[7]}}, mb0};
    else if (MEM_C == 2'b01) mem_rdata = {{16{MEM_S & mb1[7]}}, mb1, mb0};
  end

  always @(posedge clk) begin
    if (MEM_W) begin
      dev_mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (MEM_C != 2'b10) dev_mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (MEM_C == 2'b00 || MEM_C == 2'b11) begin
        dev_mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        dev_mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: golden byte array plus the last value each requester read back.
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_i(input logic [31:0] addr, output exp_t e);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = golden[8'(addr + 32'(i))];
    last_i = v;
    e = '{rdata: v, err: 1'b0, pulses: 1 + int'(WS)};
  endtask

  task automatic model_d(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int n = size_bytes(size);
    logic [31:0] v = '0;
    bit mis = AlignChk && ((addr % 32'(n)) != 0);
    if (mis) begin
      last_d = '0;
      e = '{rdata: 32'd0, err: 1'b1, pulses: 0};
    end else if (we) begin
      for (int i = 0; i < n; i++) golden[8'(addr + 32'(i))] = wdata[8*i +: 8];
      e = '{rdata: last_d, err: 1'b0, pulses: 1 + int'(WS)};
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = golden[8'(addr + 32'(i))];
      if (sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      last_d = v;
      e = '{rdata: v, err: 1'b0, pulses: 1 + int'(WS)};
    end
  endtask

  exp_t i_q[$];
  exp_t d_q[$];
  int   ack_order[$];
  int   pulses_seen = 0;

  // Monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk) begin
    exp_t e;
    if (MEM_R || MEM_W) begin
      pulses_seen++;
      check("mem_r_w_exclusive", {31'd0, MEM_R & MEM_W}, 32'd0);
    end
    if (i_ack || d_ack) check("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
    if (i_ack) begin
      if (i_q.size() == 0) begin
        check("i_ack_unexpected", {31'd0, i_ack}, 32'd0);
      end else begin
        e = i_q.pop_front();
        check("i_rdata", i_rdata, e.rdata);
        check("i_mem_cycles", 32'(pulses_seen), 32'(e.pulses));
      end
      ack_order.push_back(0);
      pulses_seen = 0;
    end
    if (d_ack) begin
      if (d_q.size() == 0) begin
        check("d_ack_unexpected", {31'd0, d_ack}, 32'd0);
      end else begin
        e = d_q.pop_front();
        check("d_rdata", d_rdata, e.rdata);
        check("d_err", {31'd0, d_err}, {31'd0, e.err});
        check("d_mem_cycles", 32'(pulses_seen), 32'(e.pulses));
      end
      ack_order.push_back(1);
      pulses_seen = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic is_d, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(is_d ? d_ack : i_ack) && n < 100);
    if (is_d) check("d_ack_timeout", {31'd0, d_ack}, 32'd1);
    else check("i_ack_timeout", {31'd0, i_ack}, 32'd1);
  endtask

  task automatic drive_i(input logic [31:0] addr, output int lat);
    exp_t e;
    model_i(addr, e);
    i_q.push_back(e);
    i_addr = addr;
    i_req  = 1'b1;
    wait_ack(1'b0, lat);
    i_req  = 1'b0;
    i_addr = $urandom;
  endtask

  task automatic drive_d(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    exp_t e;
    model_d(we, size, sign, addr, wdata, e);
    d_q.push_back(e);
    d_we = we; d_size = size; d_sign = sign; d_addr = addr; d_wdata = wdata;
    d_req = 1'b1;
    wait_ack(1'b1, lat);
    d_req = 1'b0;
    d_we = $urandom; d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic b_access(input logic is_d, input logic we, input logic [31:0] addr,
                          output int lat, output int pulses);
    if (is_d) begin
      b_d_we = we; b_d_size = 2'b00; b_d_sign = 1'b0; b_d_addr = addr; b_d_wdata = $urandom;
      b_d_req = 1'b1;
    end else begin
      b_i_addr = addr;
      b_i_req  = 1'b1;
    end
    lat = 0;
    pulses = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (b_mem_r || b_mem_w) pulses++;
    end while (!(is_d ? b_d_ack : b_i_ack) && lat < 100);
    b_d_req = 1'b0;
    b_i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, pulses;
    for (int i = 0; i < 256; i++) golden[i] = 8'($urandom);
    golden[0] = 8'h34; golden[1] = 8'h12; golden[2] = 8'h01; golden[3] = 8'h3C;
    for (int i = 0; i < 256; i++) dev_mem[i] <= golden[i];

    // Reset state
    #2;
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("rst_mem_ctl", {27'd0, MEM_W, MEM_R, MEM_S, MEM_C}, 32'd0);
    check("rst_busy_err", {30'd0, busy, d_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    idle(3);
    rst = 1'b0;
    idle(1);

    // Single fetch
    drive_i(32'h0, lat);
    check("t1_latency", 32'(lat), 32'(2 + WS));
    check("t1_busy_in_resp", {31'd0, busy}, 32'd1);
    idle(1);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Byte store then signed byte load
    drive_d(1'b1, 2'b10, 1'b0, 32'h7, 32'h0000_00AB, lat);
    check("t2_store_mem_c", {30'd0, MEM_C}, 32'd2);
    idle(1);
    drive_d(1'b0, 2'b10, 1'b1, 32'h7, 32'h0, lat);
    check("t2_load_latency", 32'(lat), 32'(2 + WS));
    check("t2_i_rdata_retained", i_rdata, last_i);
    idle(1);

    // Halfword at an odd address, then an aligned access
    drive_d(1'b0, 2'b01, 1'b0, 32'h85, 32'h0, lat);
    check("t5_latency", 32'(lat), AlignChk ? 32'd1 : 32'(2 + WS));
    idle(1);
    drive_d(1'b0, 2'b00, 1'b0, 32'h84, 32'h0, lat);
    idle(1);

    // Reset during the ACCESS cycle of a store
    d_we = 1'b1; d_size = 2'b00; d_sign = 1'b0; d_addr = 32'h90; d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!MEM_W && lat < 10);
    check("t6_mem_w_up", {31'd0, MEM_W}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_mem_w_drop", {31'd0, MEM_W}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    d_req = 1'b0;
    #1 rst = 1'b0;
    last_i = '0;
    last_d = '0;
    @(posedge clk);
    #1;
    idle(4);
    check("t6_d_rdata_cleared", d_rdata, 32'd0);

    // Simultaneous requests after reset: D, I, then D again
    ack_order.delete();
    fork
      drive_i(32'h10, lat);
      drive_d(1'b0, 2'b00, 1'b0, 32'h88, 32'h0, pulses);
    join
    idle(1);
    fork
      drive_i(32'h14, lat);
      drive_d(1'b0, 2'b00, 1'b0, 32'h8C, 32'h0, pulses);
    join
    idle(1);
    check("t3_ack_count", 32'(ack_order.size()), 32'd4);
    if (ack_order.size() == 4) begin
      check("t3_first", 32'(ack_order[0]), 32'd1);
      check("t3_second", 32'(ack_order[1]), 32'd0);
      check("t3_third", 32'(ack_order[2]), 32'd1);
      check("t3_fourth", 32'(ack_order[3]), 32'd0);
    end

    // Aborted store is redone and read back
    drive_d(1'b1, 2'b00, 1'b0, 32'h90, 32'hDEAD_BEEF, lat);
    check("t6_redo_latency", 32'(lat), 32'(2 + WS));
    idle(1);
    drive_d(1'b0, 2'b00, 1'b0, 32'h90, 32'h0, lat);
    idle(1);

    // Random concurrent traffic; fetches and data use disjoint address regions
    fork
      begin
        int l;
        repeat (40) begin
          idle($urandom_range(0, 3));
          drive_i({$urandom_range(0, 255), 8'h00} | (32'($urandom_range(0, 31)) << 2), l);
        end
      end
      begin
        int l;
        repeat (40) begin
          idle($urandom_range(0, 3));
          drive_d(1'($urandom), 2'($urandom), 1'($urandom),
                  32'h80 + 32'($urandom_range(0, 123)), $urandom, l);
        end
      end
    join
    idle(2);

    // Wait-state instance
    b_access(1'b1, 1'b0, 32'h40, lat, pulses);
    check("t4_load_latency", 32'(lat), 32'(2 + WS_B));
    check("t4_load_mem_r_cycles", 32'(pulses), 32'(1 + WS_B));
    check("t4_load_rdata", b_d_rdata, ~32'h40);
    idle(1);
    b_access(1'b0, 1'b0, 32'h10, lat, pulses);
    check("t4_fetch_latency", 32'(lat), 32'(2 + WS_B));
    check("t4_fetch_rdata", b_i_rdata, ~32'h10);
    idle(1);
    b_access(1'b1, 1'b1, 32'h44, lat, pulses);
    check("t4_store_mem_w_cycles", 32'(pulses), 32'(1 + WS_B));
    check("t4_store_keeps_rdata", b_d_rdata, ~32'h40);
    idle(1);
    check("t4_idle", {30'd0, b_busy, b_d_err}, 32'd0);

    check("i_queue_drained", 32'(i_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
